// File: rtl/nes_pad_pkg.sv
// rtl/nes_pad_pkg.sv - shared constants and SOCD helper for the NES pad emulator
package nes_pad_pkg;

    localparam int PAD_BITS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic [3:0] BCNT_SAT = 4'd8;

    // Opposing directions pressed together cancel each other out.
    function automatic logic [PAD_BITS-1:0] socd_clean(input logic [PAD_BITS-1:0] b);
        logic [PAD_BITS-1:0] r;
        r = b;
        if (b[BTN_UP] && b[BTN_DOWN]) begin
            r[BTN_UP]   = 1'b0;
            r[BTN_DOWN] = 1'b0;
        end
        if (b[BTN_LEFT] && b[BTN_RIGHT]) begin
            r[BTN_LEFT]  = 1'b0;
            r[BTN_RIGHT] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/nes_pad_debounce.sv
// rtl/nes_pad_debounce.sv - single-button debouncer: level must hold DEBOUNCE_CYCLES before it is accepted
module nes_pad_debounce
    import nes_pad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17
) (
    input  logic clk_in,
    input  logic nres_in,
    input  logic raw_i,
    output logic state_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             state_q, state_d;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (raw_i == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            state_d = raw_i;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge nres_in) begin
        if (!nres_in) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/nes_pad_emu.sv
// rtl/nes_pad_emu.sv - CD4021-style NES controller emulator; NES_PAD_SOCD_EN enables opposing-direction cleaning
module nes_pad_emu
    import nes_pad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17
) (
    input  logic                clk_in,
    input  logic                nres_in,
    input  logic [PAD_BITS-1:0] btn_in,
    input  logic                jp_latch_in,
    input  logic                jp_clk_in,
    output logic                jp_data_out,
    output logic [PAD_BITS-1:0] btn_state_out
);

    logic [PAD_BITS-1:0] btn_s1_q, btn_s2_q;
    logic [1:0]          latch_sync_q;
    logic [2:0]          clk_sync_q;
    logic                latch_s;
    logic                clk_rise;

    always_ff @(posedge clk_in or negedge nres_in) begin
        if (!nres_in) begin
            btn_s1_q     <= '0;
            btn_s2_q     <= '0;
            latch_sync_q <= '0;
            clk_sync_q   <= '0;
        end else begin
            btn_s1_q     <= btn_in;
            btn_s2_q     <= btn_s1_q;
            latch_sync_q <= {latch_sync_q[0], jp_latch_in};
            clk_sync_q   <= {clk_sync_q[1:0], jp_clk_in};
        end
    end

    assign latch_s  = latch_sync_q[1];
    assign clk_rise = clk_sync_q[1] & ~clk_sync_q[2];

    for (genvar i = 0; i < PAD_BITS; i++) begin : g_deb
        nes_pad_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk_in (clk_in),
            .nres_in(nres_in),
            .raw_i  (btn_s2_q[i]),
            .state_o(btn_state_out[i])
        );
    end

    logic [PAD_BITS-1:0] pad_state;
`ifdef NES_PAD_SOCD_EN
    assign pad_state = socd_clean(btn_state_out);
`else
    assign pad_state = btn_state_out;
`endif

    logic [PAD_BITS-1:0] sr_q, sr_d;
    logic [3:0]          bcnt_q, bcnt_d;
    logic                data_q;

    // Past the 8th bit the line reads "pressed", like a pad with a grounded serial input.
    always_comb begin
        sr_d   = sr_q;
        bcnt_d = bcnt_q;
        if (latch_s) begin
            sr_d   = pad_state;
            bcnt_d = '0;
        end else if (clk_rise) begin
            if (bcnt_q < BCNT_SAT) begin
                sr_d   = {1'b1, sr_q[PAD_BITS-1:1]};
                bcnt_d = bcnt_q + 4'd1;
            end else begin
                sr_d = '1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge nres_in) begin
        if (!nres_in) begin
            sr_q   <= '0;
            bcnt_q <= '0;
            data_q <= 1'b1;
        end else begin
            sr_q   <= sr_d;
            bcnt_q <= bcnt_d;
            data_q <= ~sr_q[0];
        end
    end

    assign jp_data_out = data_q;

endmodule

// File: tb/tb_nes_pad_emu.sv
// tb/tb_nes_pad_emu.sv - randomized self-checking bench for nes_pad_emu against a read-sequence model
`timescale 1ns/1ps
module tb_nes_pad_emu;

    logic       clk_in = 1'b0;
    logic       nres_in;
    logic [7:0] btn_in;
    logic       jp_latch_in;
    logic       jp_clk_in;
    logic       jp_data_out;
    logic [7:0] btn_state_out;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    nes_pad_emu #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk_in       (clk_in),
        .nres_in      (nres_in),
        .btn_in       (btn_in),
        .jp_latch_in  (jp_latch_in),
        .jp_clk_in    (jp_clk_in),
        .jp_data_out  (jp_data_out),
        .btn_state_out(btn_state_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pressed bits the pad reports on a read, given the accepted button levels.
    function automatic logic [7:0] pad_model(input logic [7:0] b);
        logic [7:0] r;
        r = b;
`ifdef NES_PAD_SOCD_EN
        if (b[4] && b[5]) begin r[4] = 1'b0; r[5] = 1'b0; end
        if (b[6] && b[7]) begin r[6] = 1'b0; r[7] = 1'b0; end
`endif
        return r;
    endfunction

    // Serial line level for read position k: buttons first, then "pressed" forever.
    function automatic logic line_model(input logic [7:0] pad, input int k);
        if (k < 8) return ~pad[k];
        return 1'b0;
    endfunction

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_in);
    endtask

    task automatic set_btn(input logic [7:0] b);
        @(negedge clk_in);
        btn_in = b;
        cycles(10);
    endtask

    task automatic latch_pulse();
        @(negedge clk_in);
        jp_latch_in = 1'b1;
        cycles(3);
        jp_latch_in = 1'b0;
        cycles(3);
    endtask

    task automatic clk_pulse();
        @(negedge clk_in);
        jp_clk_in = 1'b1;
        cycles(3);
        jp_clk_in = 1'b0;
        cycles(3);
    endtask

    task automatic read_seq(input string tag, input logic [7:0] btn, input int nclk);
        logic [7:0] pad;
        pad = pad_model(btn);
        latch_pulse();
        check($sformatf("%s bit0", tag), 32'(jp_data_out), 32'(line_model(pad, 0)));
        for (int k = 1; k <= nclk; k++) begin
            clk_pulse();
            check($sformatf("%s bit%0d", tag, k), 32'(jp_data_out), 32'(line_model(pad, k)));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p, g;
        int len;

        nres_in     = 1'b0;
        btn_in      = 8'h00;
        jp_latch_in = 1'b0;
        jp_clk_in   = 1'b0;
        cycles(3);
        nres_in = 1'b1;
        cycles(2);
        check("reset data", 32'(jp_data_out), 32'h1);
        check("reset state", 32'(btn_state_out), 32'h00);

        set_btn(8'h09);
        check("a_start state", 32'(btn_state_out), 32'h09);
        read_seq("a_start", 8'h09, 10);

        // Shift-clock pin edge must appear on the line exactly 4 clk_in cycles later.
        set_btn(8'h01);
        latch_pulse();
        check("lat pre", 32'(jp_data_out), 32'h0);
        @(negedge clk_in);
        jp_clk_in = 1'b1;
        cycles(3);
        check("lat 3cyc", 32'(jp_data_out), 32'h0);
        cycles(1);
        check("lat 4cyc", 32'(jp_data_out), 32'h1);
        jp_clk_in = 1'b0;
        cycles(3);

        set_btn(8'h00);
        @(negedge clk_in);
        btn_in = 8'h02;
        cycles(2);
        btn_in = 8'h00;
        cycles(10);
        check("glitch state", 32'(btn_state_out), 32'h00);
        read_seq("glitch", 8'h00, 8);

        set_btn(8'h01);
        @(negedge clk_in);
        jp_latch_in = 1'b1;
        cycles(4);
        for (int i = 0; i < 3; i++) begin
            jp_clk_in = 1'b1;
            cycles(3);
            jp_clk_in = 1'b0;
            cycles(3);
            check($sformatf("held latch %0d", i), 32'(jp_data_out), 32'h0);
        end
        jp_latch_in = 1'b0;
        cycles(3);
        for (int i = 0; i < 3; i++) clk_pulse();
        check("mid seq bit3", 32'(jp_data_out), 32'h1);
        latch_pulse();
        check("relatch bitA", 32'(jp_data_out), 32'h0);

        set_btn(8'h30);
        check("updown state", 32'(btn_state_out), 32'h30);
        read_seq("updown", 8'h30, 8);

        // Button changes during a read must not disturb the captured snapshot.
        set_btn(8'h5A);
        latch_pulse();
        btn_in = 8'hA5;
        for (int k = 1; k <= 8; k++) begin
            clk_pulse();
            check($sformatf("frozen bit%0d", k), 32'(jp_data_out), 32'(line_model(pad_model(8'h5A), k)));
        end
        cycles(6);

        for (int it = 0; it < 10; it++) begin
            p = 8'($urandom);
            set_btn(p);
            g = 8'($urandom) | 8'h01;
            len = $urandom_range(1, 3);
            @(negedge clk_in);
            btn_in = p ^ g;
            cycles(len);
            btn_in = p;
            cycles(10);
            check($sformatf("rand%0d state", it), 32'(btn_state_out), 32'(p));
            read_seq($sformatf("rand%0d", it), p, $urandom_range(0, 10));
        end

        set_btn(8'hA5);
        latch_pulse();
        for (int i = 0; i < 4; i++) clk_pulse();
        @(negedge clk_in);
        #2;
        nres_in = 1'b0;
        #1;
        check("async rst data", 32'(jp_data_out), 32'h1);
        check("async rst state", 32'(btn_state_out), 32'h00);
        cycles(2);
        nres_in = 1'b1;
        cycles(12);
        check("post rst state", 32'(btn_state_out), 32'hA5);
        read_seq("post rst", 8'hA5, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nes_pad_emu.md
Name: nes_pad_emu

Overview:
- Emulates a standard NES controller (CD4021-style 8-bit parallel-in/serial-out register) so on-board buttons can drive the rp2a03 joypad port.
- Replaces the constant-1 tie-off on the NES_JOYPAD_DATA1/2 nets in nes_top.
- Consumes jp_latch and jp_clk from rp2a03 and produces the serial jp_data line; one instance per pad.
- Raw buttons are synchronized and debounced before being loaded.

Parameters:
- DEBOUNCE_CYCLES, 100000: clk_in cycles a raw button must hold its new level before the debounced state changes (1 ms at 100 MHz); minimum 2.
- CNT_W, 17: width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk_in  input  1  system clock (CLK_100MHZ).
- nres_in  input  1  asynchronous active-low reset.
- btn_in  input  8  raw buttons, active-high pressed. Bit order: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
- jp_latch_in  input  1  latch from rp2a03; high = parallel load.
- jp_clk_in  input  1  shift clock from rp2a03; shifts on the rising edge.
- jp_data_out  output  1  serial data, active-low (0 = pressed), matching the rp2a03 jp_data input polarity.
- btn_state_out  output  8  debounced button state, active-high (status/debug).

Behaviour:
- Reset (nres_in low, asynchronous):
  - all synchronizers, debounce counters and btn_state_out go to 0;
  - shift register goes to 8'h00;
  - bit counter goes to 0;
  - jp_data_out goes to 1 (idle, nothing pressed).
- Input sync:
  - btn_in, jp_latch_in and jp_clk_in each pass through 2 flops;
  - jp_clk rising edge is detected from the 2nd and 3rd flops.
- Debounce, per button:
  - counter resets to 0 whenever the synced raw level equals btn_state_out[i];
  - otherwise the counter increments;
  - when the count reaches DEBOUNCE_CYCLES-1, btn_state_out[i] takes the raw level and the counter clears;
  - a glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Shift register sr[7:0] and bit counter bcnt (0..8, saturating):
  - Synced latch high: every cycle sr <= pad_state (see Optional Feature) and bcnt <= 0. Latch has priority over a simultaneous clk edge.
  - Latch low, clk rising edge, bcnt < 8: sr <= {1'b1, sr[7:1]} and bcnt++.
  - Latch low, clk rising edge, bcnt == 8: sr <= 8'hFF and bcnt stays 8. After 8 reads the line reads "pressed" (logic 1 to the CPU), like an official pad with grounded serial input.
- jp_data_out is registered and equals ~sr[0].
  - Latency: 1 cycle after sr updates.
  - Total latency is 4 clk_in cycles from a pin edge of jp_latch_in or jp_clk_in.
- Button changes during a read sequence do not affect sr until the next latch.
- A latch asserted mid-sequence (bcnt = 0..8) reloads immediately and restarts at bit 0 (A).
- Reset mid-sequence returns to the idle state above; the next latch starts a fresh read.

Optional Feature:
- Macro NES_PAD_SOCD_EN.
- Defined:
  - pad_state is btn_state_out with opposing directions cleaned: Up&Down both pressed clears both bits 4 and 5; Left&Right both pressed clears bits 6 and 7.
  - Cleaning is combinational between the debounce stage and the sr load, so load latency is unchanged.
  - btn_state_out stays uncleaned.
- Undefined: pad_state = btn_state_out and impossible combinations pass through unchanged.

Decomposition:
- Package nes_pad_pkg:
  - button index localparams BTN_A..BTN_RIGHT (0..7);
  - PAD_BITS = 8;
  - the saturation count value 8.
- Sub-module nes_pad_debounce: one synchronized input, counter, one debounced output. Parameters DEBOUNCE_CYCLES and CNT_W; instanced 8 times via generate.
- Sync, edge detect, shift register and SOCD logic stay in nes_pad_emu.

Test Plan:
- Reset release with btn_in=8'h00, DEBOUNCE_CYCLES=4 → jp_data_out=1 and btn_state_out=8'h00.
- Hold btn_in=8'h09 (A+Start) for 10 cycles → btn_state_out=8'h09. Then latch pulse + 8 clk pulses → jp_data_out per bit: 0,1,1,0,1,1,1,1. A 9th and 10th clk pulse → 0,0.
- Pulse btn_in[1] high for 2 cycles only (DEBOUNCE_CYCLES=4) → btn_state_out stays 8'h00; the next read returns all 1s for bits 0..7.
- Latch held high while jp_clk toggles with btn A pressed → jp_data_out stays 0, bcnt stays 0. Latch reasserted after 3 shifts → next bit read is A again.
- btn_in=8'h30 (Up+Down) debounced, then read: with NES_PAD_SOCD_EN, bits 4,5 read 1,1; without it, bits 4,5 read 0,0. btn_state_out=8'h30 in both builds.
- nres_in asserted after 4 shifts → jp_data_out=1 and btn_state_out=8'h00 immediately (asynchronous). After release and debounce, a fresh latch restarts at bit 0.
